// File: rtl/axis_s.sv
// axis_s: AXI-Stream slave with FWFT FIFO, packet FSM and counters.
// Optional length check enabled by defining AXIS_S_LEN_CHECK_EN.
module axis_s #(
  parameter int DEPTH   = 8,
  parameter int EXP_LEN = 4
) (
  input  logic       s_axis_aclk,
  input  logic       s_axis_aresetn,
  input  logic       s_axis_tvalid,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tlast,
  output logic       s_axis_tready,
  output logic [7:0] dout,
  output logic       dout_last,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy,
  output logic [7:0] pkt_count,
  output logic       len_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, RX} state_e;

  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic [7:0]    pkt_q, pkt_d;
  logic          push, pop;

  assign s_axis_tready = (cnt_q != FULL) && s_axis_aresetn;
  assign dout_valid    = (cnt_q != '0) && s_axis_aresetn;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = dout_valid && dout_ready;
  assign dout          = dout_valid ? mem_q[rptr_q][7:0] : 8'h00;
  assign dout_last     = dout_valid ? mem_q[rptr_q][8] : 1'b0;
  assign busy          = (state_q == RX);
  assign pkt_count     = pkt_q;

  // FIFO storage, pointers and occupancy next-state
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = {s_axis_tlast, s_axis_tdata};
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Packet FSM, in-packet beat count and packet counter
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    pkt_d      = pkt_q;
    unique case (1'b1)
      push && s_axis_tlast: begin
        state_d    = IDLE;
        beat_cnt_d = 8'h00;
        pkt_d      = pkt_q + 8'h01;
      end
      push && !s_axis_tlast: begin
        state_d = RX;
        if (beat_cnt_q != 8'hFF) begin
          beat_cnt_d = beat_cnt_q + 8'h01;
        end
      end
      default: ;
    endcase
  end

  // Storage array; contents are don't-care once pointers reset
  always_ff @(posedge s_axis_aclk) begin
    mem_q <= mem_d;
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      beat_cnt_q <= 8'h00;
      pkt_q      <= 8'h00;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_q      <= pkt_d;
    end
  end

`ifdef AXIS_S_LEN_CHECK_EN
  logic       len_err_q, len_err_d;
  logic [8:0] pkt_len;

  assign pkt_len = {1'b0, beat_cnt_q} + 9'd1;
  assign len_err = len_err_q;

  // Flag a finished packet whose length differs from EXP_LEN
  always_comb begin
    len_err_d = 1'b0;
    if (push && s_axis_tlast && (pkt_len != 9'(EXP_LEN))) begin
      len_err_d = 1'b1;
    end
  end

  // One-cycle pulse register
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= len_err_d;
    end
  end
`else
  logic unused_beat_cnt;
  assign unused_beat_cnt = ^beat_cnt_q;
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_s.sv
// tb_axis_s: randomized and directed scoreboard bench for axis_s.
// Reference model tracks FIFO contents, packet state and counters.
module tb_axis_s;

  localparam int DEPTH   = 8;
  localparam int EXP_LEN = 4;
`ifdef AXIS_S_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tvalid = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       tlast = 1'b0;
  logic       dready = 1'b0;
  logic       s_axis_tready;
  logic [7:0] dout;
  logic       dout_last;
  logic       dout_valid;
  logic       busy;
  logic [7:0] pkt_count;
  logic       len_err;

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q[$];
  logic       m_busy = 1'b0;
  logic [7:0] m_pkt = 8'h00;
  int         m_beats = 0;
  logic       m_len_err = 1'b0;

  always #5 clk = ~clk;

  axis_s #(.DEPTH(DEPTH), .EXP_LEN(EXP_LEN)) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .s_axis_tvalid (tvalid),
    .s_axis_tdata  (tdata),
    .s_axis_tlast  (tlast),
    .s_axis_tready (s_axis_tready),
    .dout          (dout),
    .dout_last     (dout_last),
    .dout_valid    (dout_valid),
    .dout_ready    (dready),
    .busy          (busy),
    .pkt_count     (pkt_count),
    .len_err       (len_err)
  );

  function automatic void chk(string n, logic [8:0] act, logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endfunction

  // Monitor: compare DUT outputs against the model mid-cycle
  initial begin
    logic       ev;
    logic [8:0] ed;
    forever begin
      @(negedge clk);
      chk("tready", {8'h0, s_axis_tready},
          {8'h0, rst_n && (exp_q.size() != DEPTH)});
      ev = rst_n && (exp_q.size() != 0);
      chk("dout_valid", {8'h0, dout_valid}, {8'h0, ev});
      ed = ev ? exp_q[0] : 9'h000;
      chk("dout", {dout_last, dout}, ed);
      chk("busy", {8'h0, busy}, {8'h0, m_busy});
      chk("pkt_count", {1'b0, pkt_count}, {1'b0, m_pkt});
      chk("len_err", {8'h0, len_err}, {8'h0, m_len_err});
    end
  end

  // Model: advance to the state expected after the coming edge
  initial begin
    bit acc, pp;
    int len;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        exp_q.delete();
        m_busy = 1'b0;
        m_pkt = 8'h00;
        m_beats = 0;
        m_len_err = 1'b0;
      end else begin
        acc = tvalid && (exp_q.size() != DEPTH);
        pp  = dready && (exp_q.size() != 0);
        m_len_err = 1'b0;
        if (pp) void'(exp_q.pop_front());
        if (acc) begin
          exp_q.push_back({tlast, tdata});
          if (tlast) begin
            len = ((m_beats > 255) ? 255 : m_beats) + 1;
            m_len_err = LEN_CHK && (len != EXP_LEN);
            m_beats = 0;
            m_busy = 1'b0;
            m_pkt = m_pkt + 8'h01;
          end else begin
            m_beats++;
            m_busy = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic ok;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      ok = s_axis_tready;
      tick();
      if (ok) begin
        tvalid = 1'b0;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL send_timeout: beat %h not accepted in 100 cycles", d);
    tvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    dready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    repeat (3) tick();

    dready = 1'b0;
    tvalid = 1'b1;
    tlast  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tdata = 8'h50 + 8'(i);
      tick();
    end
    tvalid = 1'b0;
    tick();
    dready = 1'b1;
    tick();
    dready = 1'b0;
    tick();
    send(8'h58, 1'b1);
    dready = 1'b1;
    repeat (12) tick();

    send(8'hA5, 1'b1);
    repeat (2) tick();

    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    repeat (3) tick();
    send(8'h04, 1'b0);
    send(8'h05, 1'b0);
    send(8'h06, 1'b0);
    send(8'h07, 1'b1);
    repeat (3) tick();

    dready = 1'b0;
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    dready = 1'b1;
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
    send(8'hD4, 1'b1);
    repeat (3) tick();

    for (int i = 0; i < 256; i++) begin
      send(8'(i), 1'b1);
    end
    repeat (3) tick();

    for (int i = 0; i < 3000; i++) begin
      tvalid = 1'($urandom_range(0, 1));
      tdata  = 8'($urandom);
      tlast  = ($urandom_range(0, 3) == 0);
      if (i < 1500) dready = ($urandom_range(0, 3) == 0);
      else dready = ($urandom_range(0, 3) != 0);
      rst_n  = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n  = 1'b1;
    tvalid = 1'b0;
    dready = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
